trap_seq: RTL

TRAP_SEQ -- requirements
Module: trap_seq

---
 rtl/trap_seq.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/trap_seq.sv
// trap_seq: machine-mode trap / mret / CSR-op sequencer placed after commit.
// It takes one retired instruction at a time and turns it into a short,
// fixed sequence of CSR file writes, optionally followed by a one-cycle fetch
// redirect. Every output is decoded from the state register and fields latched
// at accept, so nothing on commit_* reaches csr_w* in the same cycle.
//
// Handshake: commit_valid/commit_ready are strict valid/ready. A commit is
// taken on a rising edge only when both are high. commit_ready is high only
// in IDLE and does not depend on commit_valid. While busy, every commit input
// and irq_pending is ignored, and upstream holds its instruction.
module trap_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        commit_valid,
    output logic        commit_ready,
    input  logic [63:0] commit_pc,
    input  logic        commit_is_ecall,
    input  logic        commit_is_mret,
    input  logic        commit_is_csr,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [63:0] csr_src,
    input  logic        csr_src_zero,
    input  logic [63:0] csr_old,
    input  logic [63:0] mstatus_in,
    input  logic [63:0] mtvec_in,
    input  logic [63:0] mepc_in,
    input  logic        irq_pending,
    output logic        csr_wvalid,
    output logic [11:0] csr_wa,
    output logic [63:0] csr_wd,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    output logic        busy,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CSR_WR   = 3'd1,
        T_EPC    = 3'd2,
        T_CAUSE  = 3'd3,
        T_STATUS = 3'd4,
        M_STATUS = 3'd5,
        REDIR    = 3'd6
    } state_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [1:0]  OP_RW = 2'b01;
    localparam logic [1:0]  OP_RS = 2'b10;
    localparam logic [1:0]  OP_RC = 2'b11;

    // Machine timer interrupt and environment call from M-mode.
    localparam logic [63:0] CAUSE_MTI   = {1'b1, 63'd7};
    localparam logic [63:0] CAUSE_ECALL = 64'd11;

    state_t      state;
    logic [63:0] pc_q;
    logic [11:0] addr_q;
    logic [1:0]  op_q;
    logic [63:0] src_q;
    logic        src_zero_q;
    logic [63:0] old_q;
    logic [63:0] mstatus_q;
    logic [63:0] cause_q;
    logic        mret_q;

    // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
    function automatic logic [63:0] trap_mstatus(input logic [63:0] s);
        logic [63:0] r;
        r        = s;
        r[7]     = s[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // Trap return: MIE <- MPIE, MPIE <- 1, MPP <- U.
    function automatic logic [63:0] mret_mstatus(input logic [63:0] s);
        logic [63:0] r;
        r        = s;
        r[3]     = s[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b00;
        return r;
    endfunction

    // Vectored mode only offsets asynchronous causes; exceptions use the base.
    function automatic logic [63:0] trap_target(input logic [63:0] tvec,
                                                input logic [63:0] cause);
        logic [63:0] base;
        base = {tvec[63:2], 2'b00};
        if (tvec[1:0] == 2'b01 && cause[63])
            return base + ({1'b0, cause[62:0]} << 2);
        return base;
    endfunction

    function automatic logic [63:0] csr_result(input logic [1:0]  op,
                                               input logic [63:0] old,
                                               input logic [63:0] src);
        case (op)
            OP_RS:   return old | src;
            OP_RC:   return old & ~src;
            default: return src;
        endcase
    endfunction

    // Set/clear with a zero source must not write, so side effects of the
    // write never fire for a pure CSR read.
    function automatic logic csr_write_en(input logic [1:0] op,
                                          input logic       src_zero);
        return (op == OP_RW) || ((op == OP_RS || op == OP_RC) && !src_zero);
    endfunction

    // Sequencer state and the snapshot taken when a commit is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pc_q       <= '0;
            addr_q     <= '0;
            op_q       <= '0;
            src_q      <= '0;
            src_zero_q <= 1'b0;
            old_q      <= '0;
            mstatus_q  <= '0;
            cause_q    <= '0;
            mret_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (commit_valid && commit_ready) begin
                        pc_q       <= commit_pc;
                        addr_q     <= csr_addr;
                        op_q       <= csr_op;
                        src_q      <= csr_src;
                        src_zero_q <= csr_src_zero;
                        old_q      <= csr_old;
                        mstatus_q  <= mstatus_in;
                        mret_q     <= 1'b0;
                        if (irq_pending && mstatus_in[3]) begin
                            cause_q <= CAUSE_MTI;
                            state   <= T_EPC;
                        end else if (commit_is_ecall) begin
                            cause_q <= CAUSE_ECALL;
                            state   <= T_EPC;
                        end else if (commit_is_mret) begin
                            mret_q  <= 1'b1;
                            state   <= M_STATUS;
                        end else if (commit_is_csr) begin
                            state   <= CSR_WR;
                        end
                    end
                end
                T_EPC:    state <= T_CAUSE;
                T_CAUSE:  state <= T_STATUS;
                T_STATUS: state <= REDIR;
                M_STATUS: state <= REDIR;
                CSR_WR:   state <= IDLE;
                REDIR:    state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    // Output decode: one CSR write per sequencing state, redirect only in REDIR.
    always_comb begin
        commit_ready   = (state == IDLE);
        busy           = (state != IDLE);
        csr_wvalid     = 1'b0;
        csr_wa         = '0;
        csr_wd         = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state)
            T_EPC: begin
                csr_wvalid = 1'b1;
                csr_wa     = CSR_MEPC;
                csr_wd     = pc_q;
            end
            T_CAUSE: begin
                csr_wvalid = 1'b1;
                csr_wa     = CSR_MCAUSE;
                csr_wd     = cause_q;
            end
            T_STATUS: begin
                csr_wvalid = 1'b1;
                csr_wa     = CSR_MSTATUS;
                csr_wd     = trap_mstatus(mstatus_q);
            end
            M_STATUS: begin
                csr_wvalid = 1'b1;
                csr_wa     = CSR_MSTATUS;
                csr_wd     = mret_mstatus(mstatus_q);
            end
            CSR_WR: begin
                csr_wvalid = csr_write_en(op_q, src_zero_q);
                csr_wa     = addr_q;
                csr_wd     = csr_result(op_q, old_q, src_q);
            end
            REDIR: begin
                redirect_valid = 1'b1;
                redirect_pc    = mret_q ? mepc_in : trap_target(mtvec_in, cause_q);
            end
            default: ;
        endcase
    end

    assign dbg_state = state;

endmodule
